// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a 5-stage RV32I pipeline.
//
// Decodes the instruction presented by fetch, builds its immediate, reads the
// 32x32 register file (whose write port belongs to writeback), detects load-use
// hazards against the instruction currently in the ID/EX register, and captures
// the decoded fields into the ID/EX pipeline register at the next rising edge.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset that clears the
//                           ID/EX register and the register file
//   IF_PC, IF_instr       - PC and instruction word from fetch
//   flush                 - squash the instruction in decode (EX resolved a redirect)
//   wb_we, wb_rd, wb_data - register file write port driven by writeback
//   stall                 - combinational load-use stall request to fetch/PC
//   ID_*                  - registered ID/EX fields (see individual comments)
//
// Handshake: there is no valid/ready pair here. The upstream contract is that
// fetch holds IF_PC/IF_instr steady for every cycle stall is high; a bubble
// (ID_valid=0) is loaded on any edge where flush or stall is high or when
// IF_instr is all zero. Flush has priority over stall.
module id_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ID_valid,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_rs1_data,
  output logic [31:0] ID_rs2_data,
  output logic [31:0] ID_imm,
  output logic [4:0]  ID_rs1,
  output logic [4:0]  ID_rs2,
  output logic [4:0]  ID_rd,
  output logic [2:0]  ID_funct3,
  output logic        ID_funct7b5,
  output logic        ID_alu_src,
  output logic        ID_mem_read,
  output logic        ID_mem_write,
  output logic        ID_reg_write,
  output logic        ID_mem_to_reg,
  output logic        ID_branch,
  output logic [1:0]  ID_jump,
  output logic        ID_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  f_rd;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;

  assign opcode = IF_instr[6:0];
  assign f_rd   = IF_instr[11:7];
  assign f_rs1  = IF_instr[19:15];
  assign f_rs2  = IF_instr[24:20];

  // Immediate formats, all sign-extended from instr[31]
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{IF_instr[31]}}, IF_instr[31:20]};
  assign imm_s = {{20{IF_instr[31]}}, IF_instr[31:25], IF_instr[11:7]};
  assign imm_b = {{19{IF_instr[31]}}, IF_instr[31], IF_instr[7],
                  IF_instr[30:25], IF_instr[11:8], 1'b0};
  assign imm_u = {IF_instr[31:12], 12'b0};
  assign imm_j = {{11{IF_instr[31]}}, IF_instr[31], IF_instr[19:12],
                  IF_instr[20], IF_instr[30:21], 1'b0};

  // Combinational decode results
  logic        dec_valid;
  logic        dec_illegal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        uses_rd;
  logic [31:0] dec_imm;
  logic        dec_alu_src;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic        dec_branch;
  logic [1:0]  dec_jump;

  always_comb begin
    dec_valid      = (IF_instr != 32'd0);
    dec_illegal    = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    uses_rd        = 1'b0;
    dec_imm        = 32'd0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = JUMP_NONE;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        uses_rd  = 1'b1;
      end
      OP_I_ALU: begin
        uses_rs1    = 1'b1;
        uses_rd     = 1'b1;
        dec_imm     = imm_i;
        dec_alu_src = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1       = 1'b1;
        uses_rd        = 1'b1;
        dec_imm        = imm_i;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_imm       = imm_s;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_imm    = imm_b;
        dec_branch = 1'b1;
      end
      OP_JAL: begin
        uses_rd  = 1'b1;
        dec_imm  = imm_j;
        dec_jump = JUMP_JAL;
      end
      OP_JALR: begin
        uses_rs1    = 1'b1;
        uses_rd     = 1'b1;
        dec_imm     = imm_i;
        dec_alu_src = 1'b1;
        dec_jump    = JUMP_JALR;
      end
      OP_LUI, OP_AUIPC: begin
        uses_rd     = 1'b1;
        dec_imm     = imm_u;
        dec_alu_src = 1'b1;
      end
      default: begin
        // Any non-zero word without a supported opcode goes down the pipe
        // as a marked illegal instruction with no side effects.
        dec_illegal = dec_valid;
      end
    endcase
  end

  // Unused source/destination indices collapse to x0 so they never match a
  // hazard or forwarding comparison downstream.
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign rs1_idx = uses_rs1 ? f_rs1 : 5'd0;
  assign rs2_idx = uses_rs2 ? f_rs2 : 5'd0;
  assign rd_idx  = uses_rd  ? f_rd  : 5'd0;

  // Register file. Entry 0 is cleared by reset and never written; reads of
  // index 0 are forced to zero regardless.
  logic [31:0] regs [0:31];
  logic        wb_active;

  assign wb_active = wb_we && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_active) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic [31:0] rs1_rd_data;
  logic [31:0] rs2_rd_data;

  assign rs1_rd_data = (rs1_idx == 5'd0) ? 32'd0 :
                       (BYPASS_EN && wb_active && (wb_rd == rs1_idx)) ? wb_data :
                       regs[rs1_idx];
  assign rs2_rd_data = (rs2_idx == 5'd0) ? 32'd0 :
                       (BYPASS_EN && wb_active && (wb_rd == rs2_idx)) ? wb_data :
                       regs[rs2_idx];

  // Load-use hazard. Masked indices are zero when unused and ID_rd is
  // required non-zero, so an index match implies the source is really used.
  assign stall = !reset && ID_valid && ID_mem_read && (ID_rd != 5'd0) &&
                 ((rs1_idx == ID_rd) || (rs2_idx == ID_rd));

  logic load_bubble;
  assign load_bubble = flush || stall || !dec_valid;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset || load_bubble) begin
      ID_valid      <= 1'b0;
      ID_PC         <= 32'd0;
      ID_rs1_data   <= 32'd0;
      ID_rs2_data   <= 32'd0;
      ID_imm        <= 32'd0;
      ID_rs1        <= 5'd0;
      ID_rs2        <= 5'd0;
      ID_rd         <= 5'd0;
      ID_funct3     <= 3'd0;
      ID_funct7b5   <= 1'b0;
      ID_alu_src    <= 1'b0;
      ID_mem_read   <= 1'b0;
      ID_mem_write  <= 1'b0;
      ID_reg_write  <= 1'b0;
      ID_mem_to_reg <= 1'b0;
      ID_branch     <= 1'b0;
      ID_jump       <= JUMP_NONE;
      ID_illegal    <= 1'b0;
    end else begin
      ID_valid      <= 1'b1;
      ID_PC         <= IF_PC;
      ID_rs1_data   <= rs1_rd_data;
      ID_rs2_data   <= rs2_rd_data;
      ID_imm        <= dec_imm;
      ID_rs1        <= rs1_idx;
      ID_rs2        <= rs2_idx;
      ID_rd         <= rd_idx;
      ID_funct3     <= dec_illegal ? 3'd0 : IF_instr[14:12];
      ID_funct7b5   <= dec_illegal ? 1'b0 : IF_instr[30];
      ID_alu_src    <= dec_alu_src;
      ID_mem_read   <= dec_mem_read;
      ID_mem_write  <= dec_mem_write;
      ID_reg_write  <= uses_rd && (f_rd != 5'd0);
      ID_mem_to_reg <= dec_mem_to_reg;
      ID_branch     <= dec_branch;
      ID_jump       <= dec_jump;
      ID_illegal    <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage. A table of single-instruction
// decode vectors is applied in a loop, followed by hand-written sequences for
// forwarding, load-use stalls, flush, x0 writes and mid-run reset. A second
// instance with BYPASS_EN=0 shares all inputs.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] IF_PC;
  logic [31:0] IF_instr;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall;
  logic        ID_valid;
  logic [31:0] ID_PC;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [31:0] ID_imm;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic [4:0]  ID_rd;
  logic [2:0]  ID_funct3;
  logic        ID_funct7b5;
  logic        ID_alu_src;
  logic        ID_mem_read;
  logic        ID_mem_write;
  logic        ID_reg_write;
  logic        ID_mem_to_reg;
  logic        ID_branch;
  logic [1:0]  ID_jump;
  logic        ID_illegal;

  logic        nb_stall;
  logic        nb_valid;
  logic [31:0] nb_PC;
  logic [31:0] nb_rs1_data;
  logic [31:0] nb_rs2_data;
  logic [31:0] nb_imm;
  logic [4:0]  nb_rs1;
  logic [4:0]  nb_rs2;
  logic [4:0]  nb_rd;
  logic [2:0]  nb_funct3;
  logic        nb_funct7b5;
  logic        nb_alu_src;
  logic        nb_mem_read;
  logic        nb_mem_write;
  logic        nb_reg_write;
  logic        nb_mem_to_reg;
  logic        nb_branch;
  logic [1:0]  nb_jump;
  logic        nb_illegal;

  // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump[1:0], illegal}
  logic [8:0]  ctrl;
  assign ctrl = {ID_alu_src, ID_mem_read, ID_mem_write, ID_reg_write,
                 ID_mem_to_reg, ID_branch, ID_jump, ID_illegal};

  id_stage #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_instr(IF_instr), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_rs1_data(ID_rs1_data),
    .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd(ID_rd), .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5),
    .ID_alu_src(ID_alu_src), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
    .ID_reg_write(ID_reg_write), .ID_mem_to_reg(ID_mem_to_reg), .ID_branch(ID_branch),
    .ID_jump(ID_jump), .ID_illegal(ID_illegal)
  );

  id_stage #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_instr(IF_instr), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(nb_stall),
    .ID_valid(nb_valid), .ID_PC(nb_PC), .ID_rs1_data(nb_rs1_data),
    .ID_rs2_data(nb_rs2_data), .ID_imm(nb_imm), .ID_rs1(nb_rs1), .ID_rs2(nb_rs2),
    .ID_rd(nb_rd), .ID_funct3(nb_funct3), .ID_funct7b5(nb_funct7b5),
    .ID_alu_src(nb_alu_src), .ID_mem_read(nb_mem_read), .ID_mem_write(nb_mem_write),
    .ID_reg_write(nb_reg_write), .ID_mem_to_reg(nb_mem_to_reg), .ID_branch(nb_branch),
    .ID_jump(nb_jump), .ID_illegal(nb_illegal)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7b5;
    logic [8:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[10];

  localparam logic [31:0] I_BGE     = 32'h0062D463;  // bge x5,x6,8
  localparam logic [31:0] I_LW_X7   = 32'h00402383;  // lw x7,4(x0)
  localparam logic [31:0] I_ADD_USE = 32'h00538433;  // add x8,x7,x5
  localparam logic [31:0] I_LW_X0   = 32'h00402003;  // lw x0,4(x0)
  localparam logic [31:0] I_ADD_X0  = 32'h00500433;  // add x8,x0,x5
  localparam logic [31:0] I_SW      = 32'hFE62AE23;  // sw x6,-4(x5)
  localparam logic [31:0] I_ADD_X1  = 32'h000000B3;  // add x1,x0,x0
  localparam logic [31:0] I_SUB     = 32'h406284B3;  // sub x9,x5,x6
  localparam logic [31:0] I_ADDI    = 32'h00A00293;  // addi x5,x0,10

  initial begin
    //                name     instr         pc       v  rd  rs1 rs2 imm           f3 f7 ctrl          d1     d2
    vecs[0] = '{"addi",  32'h00A00293, 32'h000, 1, 5,  0,  0,  32'h0000000A, 0, 0, 9'b100100000, 32'd0, 32'd0};
    vecs[1] = '{"lui",   32'h12345537, 32'h004, 1, 10, 0,  0,  32'h12345000, 5, 0, 9'b100100000, 32'd0, 32'd0};
    vecs[2] = '{"auipc", 32'hFFFFF197, 32'h008, 1, 3,  0,  0,  32'hFFFFF000, 7, 1, 9'b100100000, 32'd0, 32'd0};
    vecs[3] = '{"jal",   32'hFF9FF0EF, 32'h00C, 1, 1,  0,  0,  32'hFFFFFFF8, 7, 1, 9'b000100010, 32'd0, 32'd0};
    vecs[4] = '{"jalr",  32'h00008067, 32'h010, 1, 0,  1,  0,  32'h00000000, 0, 0, 9'b100000100, 32'd0, 32'd0};
    vecs[5] = '{"srai",  32'h40315213, 32'h014, 1, 4,  2,  0,  32'h00000403, 5, 1, 9'b100100000, 32'd0, 32'd0};
    vecs[6] = '{"sub",   32'h406284B3, 32'h018, 1, 9,  5,  6,  32'h00000000, 0, 1, 9'b000100000, 32'd0, 32'd5};
    vecs[7] = '{"addi_n",32'hFFF08113, 32'h01C, 1, 2,  1,  0,  32'hFFFFFFFF, 0, 1, 9'b100100000, 32'd0, 32'd0};
    vecs[8] = '{"illeg", 32'h0000007F, 32'h100, 1, 0,  0,  0,  32'h00000000, 0, 0, 9'b000000001, 32'd0, 32'd0};
    vecs[9] = '{"bubble",32'h00000000, 32'h104, 0, 0,  0,  0,  32'h00000000, 0, 0, 9'b000000000, 32'd0, 32'd0};

    reset = 1'b1; IF_PC = 32'd0; IF_instr = 32'd0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    // Reset, then release with IF_instr=0 for 3 cycles
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, ID_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", {31'd0, ID_valid}, 32'd0);
      chk("idle_ctrl", {23'd0, ctrl}, 32'd0);
      chk("idle_pc", ID_PC, 32'd0);
      chk("idle_rd", {27'd0, ID_rd}, 32'd0);
      chk("idle_stall", {31'd0, stall}, 32'd0);
    end

    // Seed x6 = 5
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'd5;
    tick();
    wb_we = 1'b0;

    // Table-driven decode vectors
    for (int i = 0; i < 10; i++) begin
      IF_instr = vecs[i].instr;
      IF_PC    = vecs[i].pc;
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, ID_valid}, {31'd0, vecs[i].valid});
      if (vecs[i].valid) chk({vecs[i].name, "_pc"}, ID_PC, vecs[i].pc);
      chk({vecs[i].name, "_rd"}, {27'd0, ID_rd}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, "_rs1"}, {27'd0, ID_rs1}, {27'd0, vecs[i].rs1});
      chk({vecs[i].name, "_rs2"}, {27'd0, ID_rs2}, {27'd0, vecs[i].rs2});
      chk({vecs[i].name, "_imm"}, ID_imm, vecs[i].imm);
      chk({vecs[i].name, "_f3"}, {29'd0, ID_funct3}, {29'd0, vecs[i].f3});
      chk({vecs[i].name, "_f7b5"}, {31'd0, ID_funct7b5}, {31'd0, vecs[i].f7b5});
      chk({vecs[i].name, "_ctrl"}, {23'd0, ctrl}, {23'd0, vecs[i].ctrl});
      chk({vecs[i].name, "_d1"}, ID_rs1_data, vecs[i].d1);
      chk({vecs[i].name, "_d2"}, ID_rs2_data, vecs[i].d2);
      chk({vecs[i].name, "_stall"}, {31'd0, stall}, 32'd0);
    end

    // bge with same-cycle writeback of x5 = 10
    IF_instr = I_BGE; IF_PC = 32'h40;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd10;
    tick();
    wb_we = 1'b0;
    chk("bge_d1_byp", ID_rs1_data, 32'd10);
    chk("bge_d2", ID_rs2_data, 32'd5);
    chk("bge_imm", ID_imm, 32'd8);
    chk("bge_ctrl", {23'd0, ctrl}, {23'd0, 9'b000001000});
    chk("bge_f3", {29'd0, ID_funct3}, 32'd5);
    chk("bge_d1_nobyp", nb_rs1_data, 32'd0);
    chk("bge_d2_nobyp", nb_rs2_data, 32'd5);

    // Load-use: lw x7 then add x8,x7,x5
    IF_instr = I_LW_X7; IF_PC = 32'h44;
    tick();
    chk("lw_rd", {27'd0, ID_rd}, 32'd7);
    chk("lw_ctrl", {23'd0, ctrl}, {23'd0, 9'b110110000});
    chk("lw_imm", ID_imm, 32'd4);
    chk("lw_stall0", {31'd0, stall}, 32'd0);
    IF_instr = I_ADD_USE; IF_PC = 32'h48;
    #1;
    chk("lu_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, ID_valid}, 32'd0);
    chk("lu_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, ID_valid}, 32'd1);
    chk("lu_add_rs1", {27'd0, ID_rs1}, 32'd7);
    chk("lu_add_rs2", {27'd0, ID_rs2}, 32'd5);
    chk("lu_add_rd", {27'd0, ID_rd}, 32'd8);
    chk("lu_add_d2", ID_rs2_data, 32'd10);
    chk("lu_add_stall", {31'd0, stall}, 32'd0);

    // Load to x0: no stall
    IF_instr = I_LW_X0; IF_PC = 32'h4C;
    tick();
    chk("lw0_regw", {31'd0, ID_reg_write}, 32'd0);
    chk("lw0_memrd", {31'd0, ID_mem_read}, 32'd1);
    IF_instr = I_ADD_X0; IF_PC = 32'h50;
    #1;
    chk("lw0_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lw0_add_valid", {31'd0, ID_valid}, 32'd1);
    chk("lw0_add_rd", {27'd0, ID_rd}, 32'd8);

    // Store with negative offset
    IF_instr = I_SW; IF_PC = 32'h54;
    tick();
    chk("sw_imm", ID_imm, 32'hFFFFFFFC);
    chk("sw_ctrl", {23'd0, ctrl}, {23'd0, 9'b101000000});
    chk("sw_rd", {27'd0, ID_rd}, 32'd0);
    chk("sw_d1", ID_rs1_data, 32'd10);
    chk("sw_d2", ID_rs2_data, 32'd5);

    // Flush together with a load-use stall condition
    IF_instr = I_LW_X7; IF_PC = 32'h58;
    tick();
    IF_instr = I_ADD_USE; IF_PC = 32'h5C; flush = 1'b1;
    #1;
    chk("fl_stall_req", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    chk("fl_bubble", {31'd0, ID_valid}, 32'd0);
    chk("fl_no_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("fl_add_valid", {31'd0, ID_valid}, 32'd1);
    chk("fl_add_rd", {27'd0, ID_rd}, 32'd8);

    // Flush of a plain instruction
    IF_instr = I_ADDI; IF_PC = 32'h60; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_addi_bubble", {31'd0, ID_valid}, 32'd0);
    chk("fl_addi_regw", {31'd0, ID_reg_write}, 32'd0);

    // Write to x0 is ignored
    IF_instr = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    IF_instr = I_ADD_X1; IF_PC = 32'h64;
    tick();
    wb_we = 1'b0;
    chk("x0_valid", {31'd0, ID_valid}, 32'd1);
    chk("x0_rd", {27'd0, ID_rd}, 32'd1);
    chk("x0_d1", ID_rs1_data, 32'd0);
    chk("x0_d2", ID_rs2_data, 32'd0);

    // Reset asserted mid-operation clears immediately and wipes registers
    IF_instr = I_SUB; IF_PC = 32'h68;
    tick();
    chk("pre_rst_d1", ID_rs1_data, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("mid_rst_pc", ID_PC, 32'd0);
    chk("mid_rst_ctrl", {23'd0, ctrl}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, ID_valid}, 32'd1);
    chk("post_rst_pc", ID_PC, 32'h68);
    chk("post_rst_d1", ID_rs1_data, 32'd0);
    chk("post_rst_d2", ID_rs2_data, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
